// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer: parses ALU command frames from RX, runs the ALU,
// and returns the double-width result to TX as two bytes, low byte first.
module alu_cmd_sequencer #(
   parameter int          DATA_WIDTH    = 8,
   parameter int          ALU_FUN_WIDTH = 4,
   parameter logic [7:0]  OP_ALU_FULL   = 8'hCC,
   parameter logic [7:0]  OP_ALU_REUSE  = 8'hDD,
   parameter int          WAIT_TIMEOUT  = 4
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic [DATA_WIDTH-1:0]     i_RX_DATA,
   input  logic                      i_RX_VALID,
   output logic [DATA_WIDTH-1:0]     o_ALU_A,
   output logic [DATA_WIDTH-1:0]     o_ALU_B,
   output logic [ALU_FUN_WIDTH-1:0]  o_ALU_FUN,
   output logic                      o_ALU_EN,
   input  logic [2*DATA_WIDTH-1:0]   i_ALU_OUT,
   input  logic                      i_ALU_VALID,
   output logic [DATA_WIDTH-1:0]     o_TX_DATA,
   output logic                      o_TX_VALID,
   input  logic                      i_TX_READY,
   output logic                      o_BUSY,
   output logic                      o_DROP,
   output logic                      o_ERR
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GET_A   = 3'd1;
   localparam logic [2:0] S_GET_B   = 3'd2;
   localparam logic [2:0] S_GET_FUN = 3'd3;
   localparam logic [2:0] S_EXEC    = 3'd4;
   localparam logic [2:0] S_WAIT    = 3'd5;
   localparam logic [2:0] S_SEND_LO = 3'd6;
   localparam logic [2:0] S_SEND_HI = 3'd7;

   localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

   logic [2:0]               state_q, state_d;
   logic [DATA_WIDTH-1:0]    alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0]    alu_b_q, alu_b_d;
   logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
   logic [2*DATA_WIDTH-1:0]  result_q, result_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]         cnt_inc;
   logic                     tx_valid_q, tx_valid_d;
   logic                     drop;
   logic                     err;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_fun_d  = alu_fun_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      tx_valid_d = tx_valid_q;
      drop       = 1'b0;
      err        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_RX_VALID) begin
               if (i_RX_DATA == OP_ALU_FULL)       state_d = S_GET_A;
               else if (i_RX_DATA == OP_ALU_REUSE) state_d = S_GET_FUN;
               else                                drop    = 1'b1;
            end
         end
         S_GET_A: begin
            if (i_RX_VALID) begin
               alu_a_d = i_RX_DATA;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (i_RX_VALID) begin
               alu_b_d = i_RX_DATA;
               state_d = S_GET_FUN;
            end
         end
         S_GET_FUN: begin
            if (i_RX_VALID) begin
               alu_fun_d = i_RX_DATA[ALU_FUN_WIDTH-1:0];
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            drop    = i_RX_VALID;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            drop = i_RX_VALID;
            // A valid arriving on the timeout cycle still wins over the error
            if (i_ALU_VALID) begin
               result_d   = i_ALU_OUT;
               tx_valid_d = 1'b1;
               state_d    = S_SEND_LO;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(WAIT_TIMEOUT)) begin
                  err     = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_SEND_LO: begin
            drop = i_RX_VALID;
            if (i_TX_READY) state_d = S_SEND_HI;
         end
         S_SEND_HI: begin
            drop = i_RX_VALID;
            if (i_TX_READY) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q    <= S_IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_fun_q  <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_fun_q  <= alu_fun_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   // TX byte is a pure function of registered state, so it cannot move while stalled
   always_comb begin
      o_TX_DATA = '0;
      if (state_q == S_SEND_LO)      o_TX_DATA = result_q[DATA_WIDTH-1:0];
      else if (state_q == S_SEND_HI) o_TX_DATA = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
   end

   assign o_ALU_A    = alu_a_q;
   assign o_ALU_B    = alu_b_q;
   assign o_ALU_FUN  = alu_fun_q;
   assign o_ALU_EN   = (state_q == S_EXEC);
   assign o_TX_VALID = tx_valid_q;
   assign o_BUSY     = (state_q != S_IDLE);
   assign o_DROP     = drop;
   assign o_ERR      = err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU model
// (0 add, 1 sub, 2 mul, 3 div) answering one cycle after enable.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_fun;
   logic        alu_en;
   logic [15:0] alu_out;
   logic        alu_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy, drop, err;

   logic        alu_mute;
   logic        last_drop;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_RX_DATA  (rx_data),
      .i_RX_VALID (rx_valid),
      .o_ALU_A    (alu_a),
      .o_ALU_B    (alu_b),
      .o_ALU_FUN  (alu_fun),
      .o_ALU_EN   (alu_en),
      .i_ALU_OUT  (alu_out),
      .i_ALU_VALID(alu_valid),
      .o_TX_DATA  (tx_data),
      .o_TX_VALID (tx_valid),
      .i_TX_READY (tx_ready),
      .o_BUSY     (busy),
      .o_DROP     (drop),
      .o_ERR      (err)
   );

   always @(posedge clk) begin
      if (rst) begin
         alu_valid <= 1'b0;
         alu_out   <= 16'h0;
      end else begin
         alu_valid <= alu_en & ~alu_mute;
         case (alu_fun)
            4'd0:    alu_out <= {8'h0, alu_a} + {8'h0, alu_b};
            4'd1:    alu_out <= {8'h0, alu_a} - {8'h0, alu_b};
            4'd2:    alu_out <= alu_a * alu_b;
            4'd3:    alu_out <= (alu_b == 8'h0) ? 16'h0 : {8'h0, alu_a / alu_b};
            default: alu_out <= 16'h0;
         endcase
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end else begin
         $display("ok   %s: %0h", tag, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      #1 last_drop = drop;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic recv_byte(input logic [7:0] exp, input string tag);
      int n = 0;
      while (!tx_valid && n < 20) begin
         step();
         n++;
      end
      if (!tx_valid) check_val({tag, "_timeout"}, 32'(tx_valid), 32'd1);
      else           check_val(tag, 32'(tx_data), 32'(exp));
      step();
   endtask

   initial begin
      rst      = 1'b1;
      rx_data  = 8'h0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      alu_mute = 1'b0;
      last_drop = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // reset state
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_txv",   32'(tx_valid), 32'd0);
      check_val("rst_en",    32'(alu_en), 32'd0);
      check_val("rst_ab",    32'({alu_a, alu_b, 4'h0, alu_fun}), 32'd0);

      // CC,05,03,00 -> 0008
      send_byte(8'hCC);
      check_val("cc_nodrop", 32'(last_drop), 32'd0);
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
      check_val("add_en",    32'(alu_en), 32'd1);
      check_val("add_ab",    32'({alu_a, alu_b}), 32'h0503);
      step();
      check_val("add_en_off", 32'(alu_en), 32'd0);
      recv_byte(8'h08, "add_lo");
      recv_byte(8'h00, "add_hi");
      check_val("add_txv_end", 32'(tx_valid), 32'd0);
      check_val("add_busy_end", 32'(busy), 32'd0);

      // CC,FF,FF,02 -> FE01, low byte exactly 3 cycles after FUN
      send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
      step(); step();
      check_val("mul_lat_txv", 32'(tx_valid), 32'd1);
      recv_byte(8'h01, "mul_lo");
      recv_byte(8'hFE, "mul_hi");

      // DD,01 reuses FF/FF -> 0000
      send_byte(8'hDD); send_byte(8'h01);
      check_val("reuse_ab",  32'({alu_a, alu_b}), 32'hFFFF);
      check_val("reuse_fun", 32'(alu_fun), 32'd1);
      recv_byte(8'h00, "sub_lo");
      recv_byte(8'h00, "sub_hi");
      check_val("reuse_ab_after", 32'({alu_a, alu_b}), 32'hFFFF);

      // junk byte in IDLE
      send_byte(8'h55);
      check_val("idle_drop", 32'(last_drop), 32'd1);
      check_val("idle_drop_busy", 32'(busy), 32'd0);

      // CC,0A,02,03 with backpressure, 77 arriving during SEND_LO
      tx_ready = 1'b0;
      send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h02); send_byte(8'h03);
      step(); step();
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("bp_txv_%0d", i), 32'(tx_valid), 32'd1);
         check_val($sformatf("bp_data_%0d", i), 32'(tx_data), 32'h05);
         if (i == 2) begin
            send_byte(8'h77);
            check_val("send_drop", 32'(last_drop), 32'd1);
         end else begin
            step();
         end
      end
      tx_ready = 1'b1;
      recv_byte(8'h05, "div_lo");
      recv_byte(8'h00, "div_hi");

      // ALU never answers -> timeout error, no TX
      alu_mute = 1'b1;
      send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
      check_val("to_en", 32'(alu_en), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check_val($sformatf("to_err_%0d", k), 32'(err), (k == 4) ? 32'd1 : 32'd0);
         check_val($sformatf("to_txv_%0d", k), 32'(tx_valid), 32'd0);
      end
      step();
      check_val("to_busy_end", 32'(busy), 32'd0);
      check_val("to_err_end",  32'(err), 32'd0);
      alu_mute = 1'b0;

      // reset while in SEND_HI
      tx_ready = 1'b0;
      send_byte(8'hCC); send_byte(8'h02); send_byte(8'h03); send_byte(8'h02);
      step(); step();
      check_val("rh_lo", 32'(tx_data), 32'h06);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      check_val("rh_in_hi", 32'({7'h0, tx_valid, tx_data}), 32'h100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("rh_txv",  32'(tx_valid), 32'd0);
      check_val("rh_busy", 32'(busy), 32'd0);
      check_val("rh_regs", 32'({alu_a, alu_b, 4'h0, alu_fun}), 32'd0);
      tx_ready = 1'b1;
      send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
      recv_byte(8'h07, "post_rst_lo");
      recv_byte(8'h00, "post_rst_hi");
      check_val("post_rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
